// File: rtl/xctrl_ws.sv
// xctrl_ws: parametrised accumulator controller with wait-state memory handshake.
// Fetches {opcode, imm} words by pc and executes them against acc and carry flag C.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   pc                         address of the current instruction
//   instr_valid, instruction   instruction word for pc and its qualifier
//   rw_req, rw_rnw, rw_addr    data memory request, direction (1 = read), address
//   data_to_wr                 write data (acc at issue)
//   data_to_rd, rw_ack         read data and request completion
//   acc, carry, halted         architectural state and HALT indication
module xctrl_ws #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMM_W      = 8,
    parameter int unsigned IADDR_W    = 10,
    parameter int unsigned INT_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [IADDR_W-1:0]    pc,
    input  logic                  instr_valid,
    input  logic [IMM_W+3:0]      instruction,
    output logic                  rw_req,
    output logic                  rw_rnw,
    output logic [INT_ADDR_W-1:0] rw_addr,
    output logic [DATA_W-1:0]     data_to_wr,
    input  logic [DATA_W-1:0]     data_to_rd,
    input  logic                  rw_ack,
    output logic [DATA_W-1:0]     acc,
    output logic                  carry,
    output logic                  halted
);

    typedef enum logic [1:0] {StFetch, StMemWait, StHalt} state_e;

    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpRdw  = 4'h2;
    localparam logic [3:0] OpWrw  = 4'h3;
    localparam logic [3:0] OpAdd  = 4'h4;
    localparam logic [3:0] OpAddc = 4'h5;
    localparam logic [3:0] OpSub  = 4'h6;
    localparam logic [3:0] OpAddi = 4'h7;
    localparam logic [3:0] OpAnd  = 4'h8;
    localparam logic [3:0] OpXor  = 4'h9;
    localparam logic [3:0] OpBeq  = 4'hA;
    localparam logic [3:0] OpBne  = 4'hB;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [IADDR_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic                  rw_req_q, rw_req_d;
    logic                  rw_rnw_q, rw_rnw_d;
    logic [INT_ADDR_W-1:0] rw_addr_q, rw_addr_d;
    logic [DATA_W-1:0]     data_to_wr_q, data_to_wr_d;
    logic                  halted_q, halted_d;

    logic [3:0]            opcode;
    logic [IMM_W-1:0]      imm;
    logic [DATA_W-1:0]     sx_data;
    logic [IADDR_W-1:0]    sx_pc;
    logic [INT_ADDR_W-1:0] imm_addr;
    logic [IADDR_W-1:0]    pc_inc;

    assign opcode = instruction[IMM_W+3:IMM_W];
    assign imm    = instruction[IMM_W-1:0];
    assign pc_inc = pc_q + IADDR_W'(1);

    // Immediate is sign-extended when narrower than the target, truncated otherwise.
    if (IMM_W < DATA_W) begin : g_sx_data_ext
        assign sx_data = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_sx_data_trunc
        assign sx_data = imm[DATA_W-1:0];
    end

    if (IMM_W < IADDR_W) begin : g_sx_pc_ext
        assign sx_pc = {{(IADDR_W - IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_sx_pc_trunc
        assign sx_pc = imm[IADDR_W-1:0];
    end

    if (INT_ADDR_W <= IMM_W) begin : g_addr_trunc
        assign imm_addr = imm[INT_ADDR_W-1:0];
    end else begin : g_addr_ext
        assign imm_addr = {{(INT_ADDR_W - IMM_W){1'b0}}, imm};
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pc_d         = pc_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        rw_req_d     = rw_req_q;
        rw_rnw_d     = rw_rnw_q;
        rw_addr_d    = rw_addr_q;
        data_to_wr_d = data_to_wr_q;
        halted_d     = halted_q;

        unique case (state_q)
            StFetch: begin
                if (instr_valid) begin
                    case (opcode)
                        OpLdi: begin
                            acc_d = sx_data;
                            pc_d  = pc_inc;
                        end
                        OpAddi: begin
                            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, sx_data};
                            pc_d = pc_inc;
                        end
                        OpBeq: pc_d = (acc_q == '0) ? pc_q + sx_pc : pc_inc;
                        OpBne: pc_d = (acc_q != '0) ? pc_q + sx_pc : pc_inc;
                        OpHalt: begin
                            halted_d = 1'b1;
                            state_d  = StHalt;
                        end
                        OpRdw, OpWrw, OpAdd, OpAddc, OpSub, OpAnd, OpXor: begin
                            op_d         = opcode;
                            rw_req_d     = 1'b1;
                            rw_rnw_d     = (opcode != OpWrw);
                            rw_addr_d    = imm_addr;
                            data_to_wr_d = acc_q;
                            state_d      = StMemWait;
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            StMemWait: begin
                if (rw_ack) begin
                    rw_req_d = 1'b0;
                    pc_d     = pc_inc;
                    state_d  = StFetch;
                    case (op_q)
                        OpRdw:  acc_d = data_to_rd;
                        OpAdd:  {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data_to_rd};
                        OpAddc: {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data_to_rd}
                                                   + {{DATA_W{1'b0}}, carry_q};
                        // Borrow falls out as the top bit of the widened difference.
                        OpSub:  {carry_d, acc_d} = {1'b0, acc_q} - {1'b0, data_to_rd};
                        OpAnd:  acc_d = acc_q & data_to_rd;
                        OpXor:  acc_d = acc_q ^ data_to_rd;
                        default: ;
                    endcase
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            op_q         <= 4'h0;
            pc_q         <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            rw_req_q     <= 1'b0;
            rw_rnw_q     <= 1'b1;
            rw_addr_q    <= '0;
            data_to_wr_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pc_q         <= pc_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            rw_req_q     <= rw_req_d;
            rw_rnw_q     <= rw_rnw_d;
            rw_addr_q    <= rw_addr_d;
            data_to_wr_q <= data_to_wr_d;
            halted_q     <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign rw_req     = rw_req_q;
    assign rw_rnw     = rw_rnw_q;
    assign rw_addr    = rw_addr_q;
    assign data_to_wr = data_to_wr_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_xctrl_ws.sv
// Testbench for xctrl_ws: directed scenarios plus a random program run against an
// instruction-level reference model (architectural state + data memory image).
module tb_xctrl_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pc;
    logic        instr_valid;
    logic [11:0] instruction;
    logic        rw_req;
    logic        rw_rnw;
    logic [7:0]  rw_addr;
    logic [7:0]  data_to_wr;
    logic [7:0]  data_to_rd;
    logic        rw_ack;
    logic [7:0]  acc;
    logic        carry;
    logic        halted;

    logic [11:0] prog [1024];
    logic [7:0]  dmem [256];
    int          m_mem [256];
    int          m_pc, m_acc, m_c, m_halted;
    int          ack_delay;
    int          wait_cnt;
    int          checks;
    int          errors;

    xctrl_ws #(
        .DATA_W(8),
        .IMM_W(8),
        .IADDR_W(10),
        .INT_ADDR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .rw_req(rw_req),
        .rw_rnw(rw_rnw),
        .rw_addr(rw_addr),
        .data_to_wr(data_to_wr),
        .data_to_rd(data_to_rd),
        .rw_ack(rw_ack),
        .acc(acc),
        .carry(carry),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign instruction = prog[pc];

    // Data memory responder: acknowledges after ack_delay wait cycles.
    always @(negedge clk) begin
        if (rw_req) begin
            if (wait_cnt >= ack_delay) begin
                rw_ack = 1'b1;
                data_to_rd = rw_rnw ? dmem[rw_addr] : 8'($urandom);
                if (!rw_rnw) dmem[rw_addr] = data_to_wr;
            end else begin
                rw_ack = 1'b0;
                data_to_rd = 8'($urandom);
            end
            wait_cnt++;
        end else begin
            rw_ack = 1'b0;
            wait_cnt = 0;
            data_to_rd = 8'($urandom);
        end
    end

    task automatic set_mem(input int addr, input int val);
        dmem[addr] = val[7:0];
        m_mem[addr] = val;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 12'h000;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 0;
        m_acc = 0;
        m_c = 0;
        m_halted = 0;
    endtask

    // Executes the instruction at the model pc, waits its expected latency, compares state.
    task automatic run_instr(input int delay);
        logic [11:0] w;
        int op, imm, m, cyc, s, off;
        w = prog[m_pc];
        op = int'(w[11:8]);
        imm = int'(w[7:0]);
        m = m_mem[imm];
        off = (imm >= 128) ? imm - 256 : imm;
        ack_delay = delay;
        cyc = (op inside {2, 3, 4, 5, 6, 8, 9}) ? 2 + delay : 1;
        case (op)
            1: m_acc = imm;
            2: m_acc = m;
            3: m_mem[imm] = m_acc;
            4: begin s = m_acc + m; m_acc = s % 256; m_c = (s > 255); end
            5: begin s = m_acc + m + m_c; m_acc = s % 256; m_c = (s > 255); end
            6: begin m_c = (m_acc < m); m_acc = (m_acc - m + 256) % 256; end
            7: begin s = m_acc + imm; m_acc = s % 256; m_c = (s > 255); end
            8: m_acc = m_acc & m;
            9: m_acc = m_acc ^ m;
            default: ;
        endcase
        if (op == 15) m_halted = 1;
        else if ((op == 10 && m_acc == 0) || (op == 11 && m_acc != 0))
            m_pc = (m_pc + off + 1024) % 1024;
        else m_pc = (m_pc + 1) % 1024;
        instr_valid = 1'b1;
        repeat (cyc) @(posedge clk);
        #1;
        checks++;
        if (pc !== m_pc[9:0]) begin
            errors++;
            $display("FAIL run_pc op=%0h: got %h expected %h", op, pc, m_pc[9:0]);
        end
        checks++;
        if (acc !== m_acc[7:0]) begin
            errors++;
            $display("FAIL run_acc op=%0h: got %h expected %h", op, acc, m_acc[7:0]);
        end
        checks++;
        if ({carry, halted, rw_req} !== {m_c[0], m_halted[0], 1'b0}) begin
            errors++;
            $display("FAIL run_flags op=%0h: got c/h/req=%b expected %b", op,
                     {carry, halted, rw_req}, {m_c[0], m_halted[0], 1'b0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        #3;
        checks++;
        if ({pc, acc, carry, rw_req, rw_rnw, rw_addr, data_to_wr, halted} !==
            {10'h000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h acc=%h c=%b req=%b rnw=%b addr=%h wd=%h h=%b expected all zero with rnw=1",
                     pc, acc, carry, rw_req, rw_rnw, rw_addr, data_to_wr, halted);
        end
        do_reset();
        clear_prog();
        prog[0] = 12'h1FF;
        prog[1] = 12'h701;
        prog[2] = 12'h107;
        run_instr(0);
        run_instr(0);
        run_instr(0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pc, acc, carry, rw_req, halted} !== {10'h000, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got pc=%h acc=%h c=%b req=%b h=%b expected zeros",
                     pc, acc, carry, rw_req, halted);
        end
    endtask

    task automatic test_write();
        do_reset();
        clear_prog();
        prog[0] = 12'h103;
        prog[1] = 12'h306;
        run_instr(0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rw_req, rw_rnw, rw_addr, data_to_wr} !== {1'b1, 1'b0, 8'h06, 8'h03}) begin
            errors++;
            $display("FAIL write_issue: got req=%b rnw=%b addr=%h wd=%h expected 1 0 06 03",
                     rw_req, rw_rnw, rw_addr, data_to_wr);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checks++;
        if ({rw_req, pc, dmem[6]} !== {1'b0, 10'h002, 8'h03}) begin
            errors++;
            $display("FAIL write_done: got req=%b pc=%h mem6=%h expected 0 002 03",
                     rw_req, pc, dmem[6]);
        end
        m_mem[6] = 3;
        m_pc = 2;
    endtask

    task automatic test_read_wait();
        int hi;
        do_reset();
        clear_prog();
        set_mem(5, 'hA5);
        prog[0] = 12'h205;
        ack_delay = 3;
        hi = 0;
        instr_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (rw_req) hi++;
            if (c == 4) begin
                checks++;
                if ({acc, pc} !== {8'h00, 10'h000}) begin
                    errors++;
                    $display("FAIL read_pending: got acc=%h pc=%h expected 00 000", acc, pc);
                end
            end
            if (c == 5) begin
                instr_valid = 1'b0;
                checks++;
                if ({acc, pc} !== {8'hA5, 10'h001}) begin
                    errors++;
                    $display("FAIL read_done: got acc=%h pc=%h expected A5 001", acc, pc);
                end
            end
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL read_req_cycles: got %0d expected 4", hi);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({acc, pc} !== {8'hA5, 10'h001}) begin
            errors++;
            $display("FAIL stall_hold: got acc=%h pc=%h expected A5 001", acc, pc);
        end
        m_acc = 'hA5;
        m_pc = 1;
    endtask

    task automatic test_arith();
        do_reset();
        clear_prog();
        set_mem('h10, 'h02);
        set_mem('h11, 'h00);
        prog[0] = 12'h1FF;
        prog[1] = 12'h410;
        prog[2] = 12'h511;
        prog[3] = 12'h7FD;
        run_instr(0);
        run_instr(1);
        checks++;
        if ({carry, acc} !== 9'h101) begin
            errors++;
            $display("FAIL add: got c=%b acc=%h expected 1 01", carry, acc);
        end
        run_instr(0);
        checks++;
        if ({carry, acc} !== 9'h002) begin
            errors++;
            $display("FAIL addc: got c=%b acc=%h expected 0 02", carry, acc);
        end
        run_instr(2);
        instr_valid = 1'b0;
        checks++;
        if ({carry, acc} !== 9'h0FF) begin
            errors++;
            $display("FAIL addi: got c=%b acc=%h expected 0 FF", carry, acc);
        end
    endtask

    task automatic test_sub_xor();
        do_reset();
        clear_prog();
        set_mem('h20, 'hA5);
        set_mem('h21, 'hB5);
        prog[0] = 12'h15A;
        prog[1] = 12'h620;
        prog[2] = 12'h921;
        run_instr(0);
        run_instr(1);
        checks++;
        if ({carry, acc} !== 9'h1B5) begin
            errors++;
            $display("FAIL sub: got c=%b acc=%h expected 1 B5", carry, acc);
        end
        run_instr(2);
        instr_valid = 1'b0;
        checks++;
        if ({carry, acc} !== 9'h100) begin
            errors++;
            $display("FAIL xor: got c=%b acc=%h expected 1 00", carry, acc);
        end
    endtask

    task automatic test_branch_halt();
        do_reset();
        clear_prog();
        prog[0] = 12'hA05;
        prog[5] = 12'hAFE;
        prog[3] = 12'hB04;
        prog[4] = 12'hF00;
        run_instr(0);
        run_instr(0);
        checks++;
        if (pc !== 10'h003) begin
            errors++;
            $display("FAIL beq_back: got pc=%h expected 003", pc);
        end
        run_instr(0);
        checks++;
        if (pc !== 10'h004) begin
            errors++;
            $display("FAIL bne_not_taken: got pc=%h expected 004", pc);
        end
        run_instr(0);
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checks++;
        if ({halted, pc, rw_req} !== {1'b1, 10'h004, 1'b0}) begin
            errors++;
            $display("FAIL halt_frozen: got h=%b pc=%h req=%b expected 1 004 0", halted, pc, rw_req);
        end
    endtask

    task automatic test_rst_mem_wait();
        do_reset();
        clear_prog();
        prog[0] = 12'h207;
        ack_delay = 10;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rw_req !== 1'b1) begin
            errors++;
            $display("FAIL memwait_entry: got req=%b expected 1", rw_req);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rw_req, pc} !== {1'b0, 10'h000}) begin
            errors++;
            $display("FAIL memwait_rst: got req=%b pc=%h expected 0 000", rw_req, pc);
        end
        do_reset();
        prog[0] = 12'h103;
        run_instr(0);
        instr_valid = 1'b0;
        checks++;
        if ({acc, pc} !== {8'h03, 10'h001}) begin
            errors++;
            $display("FAIL after_rst_fetch: got acc=%h pc=%h expected 03 001", acc, pc);
        end
    endtask

    task automatic test_random();
        int bad, op;
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            op = $urandom_range(0, 14);
            prog[i] = {op[3:0], 8'($urandom)};
        end
        for (int i = 0; i < 256; i++) set_mem(i, $urandom_range(0, 255));
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                checks++;
                if ({pc, acc, rw_req} !== {m_pc[9:0], m_acc[7:0], 1'b0}) begin
                    errors++;
                    $display("FAIL rand_stall: got pc=%h acc=%h req=%b expected %h %h 0",
                             pc, acc, rw_req, m_pc[9:0], m_acc[7:0]);
                end
            end
            run_instr($urandom_range(0, 3));
        end
        instr_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i][7:0]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_mem_image: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ack_delay = 0;
        wait_cnt = 0;
        rw_ack = 1'b0;
        data_to_rd = 8'h00;
        rst = 1'b1;
        instr_valid = 1'b0;
        clear_prog();
        for (int i = 0; i < 256; i++) set_mem(i, 0);
        test_reset();
        test_write();
        test_read_wait();
        test_arith();
        test_sub_xor();
        test_branch_halt();
        test_rst_mem_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
